wb_arbiter: RTL and testbench

Write-back arbiter for the pipelined CPU. It is the producer side of the register-file write port (RegWrite / rd / WriteData / PC). It merges the in-order pipeline WB stream with out-of-order results from the multi-cycle mul/div unit. The arbiter buffers mul/div results in a small FIFO and presents at most one register write per cycle, registered, to the register file.

---
 rtl/wb_pkg.sv | 22 ++
 rtl/wb_arbiter_if.sv | 34 +++
 rtl/wb_fifo.sv | 77 +++++++
 rtl/wb_arbiter.sv | 101 ++++++++++
 tb/tb_wb_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the write-back arbiter: defaults, FIFO entry layout
// and a small helper used to build the busy mask.
package wb_pkg;

  localparam int WB_DEPTH  = 2;
  localparam int WB_DATA_W = 32;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Layout of one queued mul/div result.
  typedef struct packed {
    logic [4:0]           rd;
    logic [WB_DATA_W-1:0] data;
    logic [31:0]          pc;
  } wb_entry_t;

  // One-hot decode of a register index into the 32-bit busy mask.
  function automatic logic [31:0] reg_onehot(input logic [4:0] r);
    return 32'd1 << r;
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Bus bundle between the pipeline / mul-div producers and the register-file
// write port. The master side is the environment, the slave side the arbiter.
interface wb_arbiter_if #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32
);
  logic                       pipe_we;
  logic [4:0]                 pipe_rd;
  logic [DATA_W-1:0]          pipe_data;
  logic [31:0]                pipe_pc;
  logic                       md_valid;
  logic                       md_ready;
  logic [4:0]                 md_rd;
  logic [DATA_W-1:0]          md_data;
  logic [31:0]                md_pc;
  logic                       RegWrite;
  logic [4:0]                 rd;
  logic [DATA_W-1:0]          WriteData;
  logic [31:0]                PC;
  logic [31:0]                busy_mask;
  logic [$clog2(DEPTH):0]     fifo_count;

  modport slave (
    input  pipe_we, pipe_rd, pipe_data, pipe_pc,
    input  md_valid, md_rd, md_data, md_pc,
    output md_ready, RegWrite, rd, WriteData, PC, busy_mask, fifo_count
  );

  modport master (
    output pipe_we, pipe_rd, pipe_data, pipe_pc,
    output md_valid, md_rd, md_data, md_pc,
    input  md_ready, RegWrite, rd, WriteData, PC, busy_mask, fifo_count
  );
endinterface

// File: rtl/wb_fifo.sv
// In-order compacting queue for mul/div results. Each edge it drops killed
// entries and the popped head, closes the gaps preserving order, then appends
// the pushed entry behind the survivors.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int  DEPTH   = WB_DEPTH,
  parameter type entry_t = wb_entry_t
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   push_i,
  input  entry_t                 push_entry_i,
  input  logic                   pop_i,
  input  logic                   kill_i,
  input  logic [4:0]             kill_rd_i,
  output entry_t                 head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic [DEPTH-1:0]       valid_o,
  output logic [DEPTH-1:0][4:0]  rd_o
);
  localparam int CW = $clog2(DEPTH) + 1;

  entry_t          entries_q [DEPTH];
  entry_t          entries_d [DEPTH];
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;

  // Next queue contents: keep survivors in order, then append the push.
  always_comb begin
    logic [CW-1:0] n;
    logic          keep;
    // NOTE: every output of this block gets a default first so no latch is inferred.
    entries_d = entries_q;
    n         = '0;
    keep      = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      keep = (CW'(i) < count_q)
          && !(pop_i && (i == 0))
          && !(kill_i && (entries_q[i].rd == kill_rd_i));
      if (keep) begin
        entries_d[n[CW-2:0]] = entries_q[i];
        n = n + CW'(1);
      end
    end
    if (push_i && (n < CW'(DEPTH))) begin
      entries_d[n[CW-2:0]] = push_entry_i;
      n = n + CW'(1);
    end
    count_d = n;
  end

  // Occupancy register; reset empties the queue.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state always uses non-blocking assignments.
    if (Rst) count_q <= '0;
    else     count_q <= count_d;
  end

  // Entry storage.
  always_ff @(posedge Clk) begin
    // NOTE: storage is deliberately not reset; validity comes from count_q alone.
    entries_q <= entries_d;
  end

  assign head_o  = entries_q[0];
  assign count_o = count_q;

  // Per-entry valid/rd view used to build the busy mask.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      valid_o[i] = (CW'(i) < count_q);
      rd_o[i]    = entries_q[i].rd;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: the pipeline always wins the register-file port,
// mul/div results queue in wb_fifo and drain on idle pipeline cycles.
// A pipeline write kills same-rd results still queued or arriving.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH  = WB_DEPTH,
  parameter int DATA_W = WB_DATA_W
) (
  input logic          Clk,
  input logic          Rst,
  wb_arbiter_if.slave  bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [4:0]        rd;
    logic [DATA_W-1:0] data;
    logic [31:0]       pc;
  } md_entry_t;

  md_entry_t              push_entry;
  md_entry_t              head;
  logic [CW-1:0]          count;
  logic [DEPTH-1:0]       valid;
  logic [DEPTH-1:0][4:0]  rds;
  logic                   pipe_wr;
  logic                   md_ready;
  logic                   push;
  logic                   pop;
  logic [31:0]            busy_mask;

  logic                   reg_write_q;
  logic [4:0]             rd_q;
  logic [DATA_W-1:0]      write_data_q;
  logic [31:0]            pc_q;

  assign pipe_wr    = bus.pipe_we && (bus.pipe_rd != REG_ZERO);
  assign md_ready   = !Rst && (count < CW'(DEPTH));
  // Accepted transfers to x0, or to the register the pipeline writes this edge, are dropped.
  assign push       = bus.md_valid && md_ready && (bus.md_rd != REG_ZERO)
                   && !(pipe_wr && (bus.md_rd == bus.pipe_rd));
  assign pop        = !pipe_wr && (count != '0);
  assign push_entry = '{rd: bus.md_rd, data: bus.md_data, pc: bus.md_pc};

  wb_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (md_entry_t)
  ) u_fifo (
    .Clk          (Clk),
    .Rst          (Rst),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .kill_i       (pipe_wr),
    .kill_rd_i    (bus.pipe_rd),
    .head_o       (head),
    .count_o      (count),
    .valid_o      (valid),
    .rd_o         (rds)
  );

  // Busy mask: registers still owed a result by a queued entry.
  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i]) busy_mask = busy_mask | reg_onehot(rds[i]);
    end
  end

  // Output register: pipeline first, else FIFO head, else idle holding fields.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      reg_write_q  <= 1'b0;
      rd_q         <= '0;
      write_data_q <= '0;
      pc_q         <= '0;
    end else if (pipe_wr) begin
      reg_write_q  <= 1'b1;
      rd_q         <= bus.pipe_rd;
      write_data_q <= bus.pipe_data;
      pc_q         <= bus.pipe_pc;
    end else if (pop) begin
      reg_write_q  <= 1'b1;
      rd_q         <= head.rd;
      write_data_q <= head.data;
      pc_q         <= head.pc;
    end else begin
      reg_write_q  <= 1'b0;
    end
  end

  assign bus.md_ready   = md_ready;
  assign bus.RegWrite   = reg_write_q;
  assign bus.rd         = rd_q;
  assign bus.WriteData  = write_data_q;
  assign bus.PC         = pc_q;
  assign bus.busy_mask  = busy_mask;
  assign bus.fifo_count = count;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, pipeline writes, mul/div draining,
// contention, full FIFO, WAW kill and mid-operation reset.
module tb_wb_arbiter;
  logic Clk;
  logic Rst;
  int   tests_run    = 0;
  int   tests_failed = 0;

  wb_arbiter_if #(.DEPTH(2), .DATA_W(32)) bus ();

  wb_arbiter #(.DEPTH(2), .DATA_W(32)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    bus.pipe_we  = 1'b0;
    bus.md_valid = 1'b0;
  endtask

  task automatic pipe(input logic [4:0] r, input logic [31:0] d, input logic [31:0] pc);
    bus.pipe_we = 1'b1; bus.pipe_rd = r; bus.pipe_data = d; bus.pipe_pc = pc;
  endtask

  task automatic md(input logic [4:0] r, input logic [31:0] d, input logic [31:0] pc);
    bus.md_valid = 1'b1; bus.md_rd = r; bus.md_data = d; bus.md_pc = pc;
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    idle();
    md(5'd3, 32'h3333, 32'h30);
    step();
    step();
    tests_run++;
    if ({bus.RegWrite, bus.fifo_count, bus.md_ready} !== {1'b0, 2'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_hold: RegWrite=%0b count=%0d md_ready=%0b want 0/0/0", bus.RegWrite, bus.fifo_count, bus.md_ready);
    end
    tests_run++;
    if ({bus.rd, bus.WriteData, bus.PC, bus.busy_mask} !== {5'd0, 32'd0, 32'd0, 32'd0}) begin
      tests_failed++;
      $display("FAIL reset_fields: rd=%0d data=%h pc=%h busy=%h want all zero", bus.rd, bus.WriteData, bus.PC, bus.busy_mask);
    end
    Rst = 1'b0;
    idle();
    #1;
    tests_run++;
    if (bus.md_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_release: md_ready=%0b want 1", bus.md_ready);
    end
  endtask

  task automatic test_pipeline();
    pipe(5'd5, 32'h1234, 32'h100);
    step();
    tests_run++;
    if ({bus.RegWrite, bus.rd, bus.WriteData, bus.PC} !== {1'b1, 5'd5, 32'h1234, 32'h100}) begin
      tests_failed++;
      $display("FAIL pipe_write: we=%0b rd=%0d data=%h pc=%h want 1/5/1234/100", bus.RegWrite, bus.rd, bus.WriteData, bus.PC);
    end
    pipe(5'd0, 32'h5555, 32'h104);
    step();
    tests_run++;
    if ({bus.RegWrite, bus.rd, bus.WriteData} !== {1'b0, 5'd5, 32'h1234}) begin
      tests_failed++;
      $display("FAIL pipe_x0: we=%0b rd=%0d data=%h want 0/5/1234", bus.RegWrite, bus.rd, bus.WriteData);
    end
    idle();
  endtask

  task automatic test_md_x0();
    md(5'd0, 32'hBEEF, 32'h180);
    step();
    idle();
    tests_run++;
    if (bus.fifo_count !== 2'd0) begin
      tests_failed++;
      $display("FAIL md_x0_queue: count=%0d want 0", bus.fifo_count);
    end
    step();
    tests_run++;
    if (bus.RegWrite !== 1'b0) begin
      tests_failed++;
      $display("FAIL md_x0_emit: we=%0b want 0", bus.RegWrite);
    end
  endtask

  task automatic test_md_path();
    md(5'd8, 32'hAAAA, 32'h200);
    step();
    idle();
    tests_run++;
    if ({bus.RegWrite, bus.fifo_count, bus.busy_mask} !== {1'b0, 2'd1, 32'h0000_0100}) begin
      tests_failed++;
      $display("FAIL md_accept: we=%0b count=%0d busy=%h want 0/1/00000100", bus.RegWrite, bus.fifo_count, bus.busy_mask);
    end
    step();
    tests_run++;
    if ({bus.RegWrite, bus.rd, bus.WriteData, bus.PC, bus.fifo_count} !== {1'b1, 5'd8, 32'hAAAA, 32'h200, 2'd0}) begin
      tests_failed++;
      $display("FAIL md_emit: we=%0b rd=%0d data=%h pc=%h count=%0d want 1/8/aaaa/200/0", bus.RegWrite, bus.rd, bus.WriteData, bus.PC, bus.fifo_count);
    end
    step();
    tests_run++;
    if ({bus.RegWrite, bus.busy_mask} !== {1'b0, 32'd0}) begin
      tests_failed++;
      $display("FAIL md_drained: we=%0b busy=%h want 0/0", bus.RegWrite, bus.busy_mask);
    end
  endtask

  task automatic test_contention();
    md(5'd8, 32'hAAAA, 32'h300);
    step();
    idle();
    pipe(5'd3, 32'h33, 32'h304);
    step();
    tests_run++;
    if ({bus.RegWrite, bus.rd, bus.WriteData, bus.fifo_count} !== {1'b1, 5'd3, 32'h33, 2'd1}) begin
      tests_failed++;
      $display("FAIL contend_n1: we=%0b rd=%0d data=%h count=%0d want 1/3/33/1", bus.RegWrite, bus.rd, bus.WriteData, bus.fifo_count);
    end
    pipe(5'd4, 32'h44, 32'h308);
    step();
    tests_run++;
    if ({bus.rd, bus.WriteData, bus.fifo_count} !== {5'd4, 32'h44, 2'd1}) begin
      tests_failed++;
      $display("FAIL contend_n2: rd=%0d data=%h count=%0d want 4/44/1", bus.rd, bus.WriteData, bus.fifo_count);
    end
    idle();
    step();
    tests_run++;
    if ({bus.RegWrite, bus.rd, bus.WriteData, bus.PC, bus.fifo_count} !== {1'b1, 5'd8, 32'hAAAA, 32'h300, 2'd0}) begin
      tests_failed++;
      $display("FAIL contend_n3: we=%0b rd=%0d data=%h pc=%h count=%0d want 1/8/aaaa/300/0", bus.RegWrite, bus.rd, bus.WriteData, bus.PC, bus.fifo_count);
    end
    step();
  endtask

  task automatic test_fifo_full();
    pipe(5'd1, 32'h1, 32'h400);
    md(5'd11, 32'hB11, 32'h410);
    step();
    pipe(5'd2, 32'h2, 32'h404);
    md(5'd12, 32'hC12, 32'h414);
    step();
    tests_run++;
    if ({bus.fifo_count, bus.md_ready, bus.busy_mask} !== {2'd2, 1'b0, 32'h0000_1800}) begin
      tests_failed++;
      $display("FAIL full_state: count=%0d md_ready=%0b busy=%h want 2/0/00001800", bus.fifo_count, bus.md_ready, bus.busy_mask);
    end
    pipe(5'd6, 32'h6, 32'h408);
    md(5'd13, 32'hD13, 32'h418);
    step();
    tests_run++;
    if ({bus.fifo_count, bus.rd, bus.busy_mask} !== {2'd2, 5'd6, 32'h0000_1800}) begin
      tests_failed++;
      $display("FAIL full_no_push: count=%0d rd=%0d busy=%h want 2/6/00001800", bus.fifo_count, bus.rd, bus.busy_mask);
    end
    idle();
    step();
    tests_run++;
    if ({bus.RegWrite, bus.rd, bus.WriteData} !== {1'b1, 5'd11, 32'hB11}) begin
      tests_failed++;
      $display("FAIL full_order0: we=%0b rd=%0d data=%h want 1/11/b11", bus.RegWrite, bus.rd, bus.WriteData);
    end
    step();
    tests_run++;
    if ({bus.RegWrite, bus.rd, bus.WriteData, bus.fifo_count} !== {1'b1, 5'd12, 32'hC12, 2'd0}) begin
      tests_failed++;
      $display("FAIL full_order1: we=%0b rd=%0d data=%h count=%0d want 1/12/c12/0", bus.RegWrite, bus.rd, bus.WriteData, bus.fifo_count);
    end
    step();
    tests_run++;
    if (bus.RegWrite !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_drained: we=%0b want 0 (rd13 must not appear)", bus.RegWrite);
    end
  endtask

  task automatic test_waw_kill();
    pipe(5'd1, 32'h1, 32'h500);
    md(5'd9, 32'h99, 32'h510);
    step();
    pipe(5'd2, 32'h2, 32'h504);
    md(5'd10, 32'h1010, 32'h514);
    step();
    tests_run++;
    if ({bus.fifo_count, bus.busy_mask} !== {2'd2, 32'h0000_0600}) begin
      tests_failed++;
      $display("FAIL kill_setup: count=%0d busy=%h want 2/00000600", bus.fifo_count, bus.busy_mask);
    end
    idle();
    pipe(5'd9, 32'h909, 32'h508);
    step();
    tests_run++;
    if ({bus.fifo_count, bus.busy_mask, bus.rd, bus.WriteData} !== {2'd1, 32'h0000_0400, 5'd9, 32'h909}) begin
      tests_failed++;
      $display("FAIL kill_queued: count=%0d busy=%h rd=%0d data=%h want 1/00000400/9/909", bus.fifo_count, bus.busy_mask, bus.rd, bus.WriteData);
    end
    idle();
    step();
    tests_run++;
    if ({bus.RegWrite, bus.rd, bus.WriteData, bus.fifo_count} !== {1'b1, 5'd10, 32'h1010, 2'd0}) begin
      tests_failed++;
      $display("FAIL kill_survivor: we=%0b rd=%0d data=%h count=%0d want 1/10/1010/0", bus.RegWrite, bus.rd, bus.WriteData, bus.fifo_count);
    end
    step();
  endtask

  task automatic test_kill_incoming();
    pipe(5'd1, 32'h1, 32'h600);
    md(5'd10, 32'hA10, 32'h610);
    step();
    pipe(5'd9, 32'h9999, 32'h604);
    md(5'd9, 32'hDEAD, 32'h614);
    #1;
    tests_run++;
    if (bus.md_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL kill_in_ready: md_ready=%0b want 1", bus.md_ready);
    end
    step();
    idle();
    tests_run++;
    if ({bus.fifo_count, bus.busy_mask, bus.rd, bus.WriteData} !== {2'd1, 32'h0000_0400, 5'd9, 32'h9999}) begin
      tests_failed++;
      $display("FAIL kill_in_drop: count=%0d busy=%h rd=%0d data=%h want 1/00000400/9/9999", bus.fifo_count, bus.busy_mask, bus.rd, bus.WriteData);
    end
    step();
    tests_run++;
    if ({bus.RegWrite, bus.rd, bus.WriteData} !== {1'b1, 5'd10, 32'hA10}) begin
      tests_failed++;
      $display("FAIL kill_in_next: we=%0b rd=%0d data=%h want 1/10/a10", bus.RegWrite, bus.rd, bus.WriteData);
    end
    step();
    tests_run++;
    if ({bus.RegWrite, bus.fifo_count} !== {1'b0, 2'd0}) begin
      tests_failed++;
      $display("FAIL kill_in_gone: we=%0b count=%0d want 0/0", bus.RegWrite, bus.fifo_count);
    end
  endtask

  task automatic test_reset_mid();
    pipe(5'd1, 32'h1, 32'h700);
    md(5'd20, 32'h2020, 32'h710);
    step();
    pipe(5'd2, 32'h2, 32'h704);
    md(5'd21, 32'h2121, 32'h714);
    step();
    tests_run++;
    if (bus.fifo_count !== 2'd2) begin
      tests_failed++;
      $display("FAIL midrst_setup: count=%0d want 2", bus.fifo_count);
    end
    idle();
    Rst = 1'b1;
    step();
    tests_run++;
    if ({bus.RegWrite, bus.rd, bus.fifo_count, bus.busy_mask} !== {1'b0, 5'd0, 2'd0, 32'd0}) begin
      tests_failed++;
      $display("FAIL midrst_clear: we=%0b rd=%0d count=%0d busy=%h want 0/0/0/0", bus.RegWrite, bus.rd, bus.fifo_count, bus.busy_mask);
    end
    Rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if ({bus.RegWrite, bus.fifo_count} !== {1'b0, 2'd0}) begin
        tests_failed++;
        $display("FAIL midrst_after%0d: we=%0b rd=%0d count=%0d want 0/-/0", i, bus.RegWrite, bus.rd, bus.fifo_count);
      end
    end
  endtask

  initial begin
    Rst           = 1'b1;
    bus.pipe_we   = 1'b0;
    bus.pipe_rd   = '0;
    bus.pipe_data = '0;
    bus.pipe_pc   = '0;
    bus.md_valid  = 1'b0;
    bus.md_rd     = '0;
    bus.md_data   = '0;
    bus.md_pc     = '0;

    test_reset();
    test_pipeline();
    test_md_x0();
    test_md_path();
    test_contention();
    test_fifo_full();
    test_waw_kill();
    test_kill_incoming();
    test_reset_mid();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
